tour_cmd_sched: RTL and testbench
=================================

// Module: tour_cmd_sched
// PURPOSE
//  Scheduler sharing the single command processor between the UART command path and the
//  on-chip tour solver. On start_tour it walks the solved knight-move list and expands each
//  L-move into two move commands: vertical leg first, then horizontal leg with fanfare.
//  Each command is issued only after the previous one has completed (send_resp).
//  Outside a tour it is a transparent pass-through of UART commands.
// PARAMETERS
//  NUM_MOVES   24   moves in a complete tour (5x5 board); mv_indx counts 0..NUM_MOVES-1
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset; one clock, asynchronous, active-high
//  start_tour     in   1   pulse from solver: move list valid, begin tour
//  move           in   8   one-hot knight move at mv_indx (table below)
//  mv_indx        out  5   index into solver move memory
//  cmd_UART       in   16  command from UART wrapper
//  cmd_rdy_UART   in   1   UART command valid
//  clr_cmd_rdy_UART out 1  clears UART command valid
//  cmd            out  16  to command processor: {opcode[3:0],heading[7:0],squares[3:0]}
//  cmd_rdy        out  1   command valid to command processor
//  clr_cmd_rdy    in   1   command accepted, from command processor
//  send_resp      in   1   command complete, from command processor
//  resp           out  8   response byte to UART: 8'hA5 = tour move done, 8'h5A = final/normal
// BEHAVIOUR
//  Reset: state IDLE, tour_mode=0, mv_indx=0, cmd_rdy=0, cmd=16'h0000, clr_cmd_rdy_UART=0, resp=8'h5A.
//  Mux: tour_mode=0 -> cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy,
//    resp=8'h5A. Combinational; zero latency.
//  tour_mode=1 -> cmd/cmd_rdy come from the registered tour command; clr_cmd_rdy_UART=0.
//    A pending UART command stays pending and is forwarded after the tour ends.
//  Move decode (dx,dy): [0](+1,+2) [1](-1,+2) [2](-2,+1) [3](-2,-1) [4](-1,-2) [5](+1,-2)
//    [6](+2,-1) [7](+2,+1).
//    - Non-one-hot: lowest set bit wins.
//    - move==0: tour ends immediately; no cmd issued; tour_mode=0, IDLE.
//  Commands:
//    - Vertical leg: opcode 4'b0100, heading 8'h00 (dy>0) or 8'h7F (dy<0), squares=|dy|.
//    - Horizontal leg: opcode 4'b0101, heading 8'h3F (dx<0) or 8'hBF (dx>0), squares=|dx|.
//  FSM:
//    - IDLE: start_tour -> tour_mode=1, mv_indx=0 -> VERT.
//      start_tour while tour_mode=1 is ignored.
//    - VERT: load cmd = vertical leg; cmd_rdy=1 -> WAIT_V_ACK.
//    - WAIT_V_ACK: hold cmd_rdy until clr_cmd_rdy; then cmd_rdy=0 -> WAIT_V_RESP.
//    - WAIT_V_RESP: send_resp -> HORZ.
//    - HORZ: load cmd = horizontal leg; cmd_rdy=1 -> WAIT_H_ACK.
//    - WAIT_H_ACK: behaves as WAIT_V_ACK.
//    - WAIT_H_RESP: on send_resp:
//      - mv_indx==NUM_MOVES-1 -> tour_mode=0, mv_indx=0 -> IDLE.
//      - else mv_indx+1 -> VERT.
//  cmd stays stable from load until send_resp; the processor samples cmd[12] at completion.
//  clr_cmd_rdy repeats while cmd_rdy=0: ignored (cmd_rdy is not re-raised before send_resp).
//  resp: on send_resp of the horizontal leg, resp=8'hA5 except the last move (8'h5A).
//    Vertical-leg resp=8'hA5. Value is registered and valid in the send_resp cycle.
//  send_resp in IDLE with tour_mode=0 belongs to a UART command; the FSM ignores it.
//  rst mid-tour: immediate return to reset state; the command processor is reset in parallel.
// STRUCTURE
//  knight_pkg: cmd opcodes (MOVE=4'b0100, MOVE_FANFARE=4'b0101), heading constants
//    (N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF), resp codes (8'hA5, 8'h5A), FSM state typedef.
//  Sub-module tour_move_decode: combinational move[7:0] -> {vert_cmd[15:0], horz_cmd[15:0], valid}.
//  Top holds the FSM, mv_indx counter, cmd register and pass-through mux.
// TESTING
//  1 tour_mode=0, cmd_UART=16'h2000, cmd_rdy_UART=1 -> cmd=16'h2000 and cmd_rdy=1 in the same
//    cycle; clr_cmd_rdy echoes to clr_cmd_rdy_UART; resp=8'h5A.
//  2 start_tour, move=8'h01 -> cmd=16'h4002 held until clr_cmd_rdy; after send_resp,
//    cmd=16'h5BF1 issued.
//  3 move=8'h10 -> vertical cmd=16'h47F2, then horizontal cmd=16'h53F1; resp=8'hA5 at each send_resp.
//  4 Full NUM_MOVES=24 tour with a responder model -> 48 commands; mv_indx 0..23;
//    last resp=8'h5A; tour_mode returns to 0.
//  5 cmd_rdy_UART=1 mid-tour -> clr_cmd_rdy_UART stays 0 and tour cmds are unaffected;
//    after the tour the UART cmd is forwarded. start_tour mid-tour is ignored.
//  6 move=8'h00 at mv_indx=5 -> no cmd, IDLE. Assert rst during WAIT_H_RESP ->
//    mv_indx=0, cmd_rdy=0, tour_mode=0.

Source files
------------

// File: rtl/tour_cmd_sched_pkg.sv
// Shared definitions for the tour command scheduler: command opcodes,
// heading constants, response codes and the scheduler state encoding.
package tour_cmd_sched_pkg;

  localparam logic [3:0] OP_MOVE         = 4'b0100;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'b0101;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_TOUR = 8'hA5;  // tour move leg finished
  localparam logic [7:0] RESP_DONE = 8'h5A;  // final tour leg / normal command

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERT,
    ST_WAIT_V_ACK,
    ST_WAIT_V_RESP,
    ST_HORZ,
    ST_WAIT_H_ACK,
    ST_WAIT_H_RESP
  } state_e;

  // Pack a command word as {opcode, heading, squares}.
  function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                           input logic [7:0] heading,
                                           input logic [3:0] squares);
    return {op, heading, squares};
  endfunction

endpackage

// File: rtl/tour_cmd_sched_if.sv
// Command-processor bus: the scheduler (master) presents a command with a
// valid flag; the processor (slave) acknowledges acceptance and completion.
interface tour_cmd_sched_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output cmd_rdy,
    output resp,
    input  clr_cmd_rdy,
    input  send_resp
  );

  modport slave (
    input  cmd,
    input  cmd_rdy,
    input  resp,
    output clr_cmd_rdy,
    output send_resp
  );
endinterface

// File: rtl/tour_cmd_sched_move_decode.sv
// Knight-move decoder: turns a one-hot move into the vertical-leg and
// horizontal-leg commands. With several bits set, the lowest one wins;
// an all-zero move is reported as invalid (end of tour).
module tour_cmd_sched_move_decode
  import tour_cmd_sched_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        valid
);

  logic       dx_neg;
  logic       dy_neg;
  logic [3:0] dx_mag;
  logic [3:0] dy_mag;

  // Priority decode of the move bits into signed leg lengths (sign + magnitude).
  always_comb begin
    dx_neg = 1'b0;
    dy_neg = 1'b0;
    dx_mag = 4'd0;
    dy_mag = 4'd0;
    valid  = 1'b1;
    casez (move)
      8'b???????1: begin dx_neg = 1'b0; dx_mag = 4'd1; dy_neg = 1'b0; dy_mag = 4'd2; end
      8'b??????10: begin dx_neg = 1'b1; dx_mag = 4'd1; dy_neg = 1'b0; dy_mag = 4'd2; end
      8'b?????100: begin dx_neg = 1'b1; dx_mag = 4'd2; dy_neg = 1'b0; dy_mag = 4'd1; end
      8'b????1000: begin dx_neg = 1'b1; dx_mag = 4'd2; dy_neg = 1'b1; dy_mag = 4'd1; end
      8'b???10000: begin dx_neg = 1'b1; dx_mag = 4'd1; dy_neg = 1'b1; dy_mag = 4'd2; end
      8'b??100000: begin dx_neg = 1'b0; dx_mag = 4'd1; dy_neg = 1'b1; dy_mag = 4'd2; end
      8'b?1000000: begin dx_neg = 1'b0; dx_mag = 4'd2; dy_neg = 1'b1; dy_mag = 4'd1; end
      8'b10000000: begin dx_neg = 1'b0; dx_mag = 4'd2; dy_neg = 1'b0; dy_mag = 4'd1; end
      default:     valid = 1'b0;
    endcase
  end

  // Vertical leg is a plain move; horizontal leg carries the fanfare opcode.
  assign vert_cmd = make_cmd(OP_MOVE, dy_neg ? HEAD_S : HEAD_N, dy_mag);
  assign horz_cmd = make_cmd(OP_MOVE_FANFARE, dx_neg ? HEAD_W : HEAD_E, dx_mag);

endmodule

// File: rtl/tour_cmd_sched.sv
// Shares the command processor between the UART command path and the tour
// solver. During a tour each knight move is issued as two legs, each waiting
// for acceptance and completion; otherwise UART commands pass straight through.
module tour_cmd_sched
  import tour_cmd_sched_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  tour_cmd_sched_if.master proc
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_e      state;
  state_e      state_nxt;
  logic        tour_mode;
  logic [4:0]  idx;
  logic [15:0] cmd_reg;
  logic [15:0] horz_hold;
  logic        cmd_rdy_reg;
  logic [7:0]  resp_reg;

  logic [15:0] dec_vert;
  logic [15:0] dec_horz;
  logic        dec_valid;

  logic        begin_tour;
  logic        end_tour;
  logic        load_vert;
  logic        load_horz;
  logic        drop_rdy;
  logic        next_move;
  logic        last_move;

  tour_cmd_sched_move_decode u_decode (
    .move     (move),
    .vert_cmd (dec_vert),
    .horz_cmd (dec_horz),
    .valid    (dec_valid)
  );

  assign last_move = (idx == LAST_IDX);
  assign mv_indx   = idx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    state_nxt  = state;
    begin_tour = 1'b0;
    end_tour   = 1'b0;
    load_vert  = 1'b0;
    load_horz  = 1'b0;
    drop_rdy   = 1'b0;
    next_move  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_tour) begin
          begin_tour = 1'b1;
          state_nxt  = ST_VERT;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_VERT: begin
        if (dec_valid) begin
          load_vert = 1'b1;
          state_nxt = ST_WAIT_V_ACK;
        end else begin
          end_tour  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_V_ACK: begin
        if (proc.clr_cmd_rdy) begin
          drop_rdy  = 1'b1;
          state_nxt = ST_WAIT_V_RESP;
        end else begin
          state_nxt = ST_WAIT_V_ACK;
        end
      end
      ST_WAIT_V_RESP: begin
        if (proc.send_resp) begin
          state_nxt = ST_HORZ;
        end else begin
          state_nxt = ST_WAIT_V_RESP;
        end
      end
      ST_HORZ: begin
        load_horz = 1'b1;
        state_nxt = ST_WAIT_H_ACK;
      end
      ST_WAIT_H_ACK: begin
        if (proc.clr_cmd_rdy) begin
          drop_rdy  = 1'b1;
          state_nxt = ST_WAIT_H_RESP;
        end else begin
          state_nxt = ST_WAIT_H_ACK;
        end
      end
      ST_WAIT_H_RESP: begin
        if (proc.send_resp) begin
          if (last_move) begin
            end_tour  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            next_move = 1'b1;
            state_nxt = ST_VERT;
          end
        end else begin
          state_nxt = ST_WAIT_H_RESP;
        end
      end
      default: begin
        end_tour  = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Tour ownership flag and move index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tour_mode <= 1'b0;
      idx       <= 5'd0;
    end else if (begin_tour) begin
      tour_mode <= 1'b1;
      idx       <= 5'd0;
    end else if (end_tour) begin
      tour_mode <= 1'b0;
      idx       <= 5'd0;
    end else if (next_move) begin
      idx       <= idx + 5'd1;
    end else begin
      idx       <= idx;
    end
  end

  // Tour command register: held stable from load until the leg completes.
  // The horizontal leg is captured together with the vertical one so both
  // legs come from the same move word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg   <= 16'h0000;
      horz_hold <= 16'h0000;
      resp_reg  <= RESP_DONE;
    end else if (load_vert) begin
      cmd_reg   <= dec_vert;
      horz_hold <= dec_horz;
      resp_reg  <= RESP_TOUR;
    end else if (load_horz) begin
      cmd_reg   <= horz_hold;
      resp_reg  <= last_move ? RESP_DONE : RESP_TOUR;
    end else begin
      cmd_reg   <= cmd_reg;
      horz_hold <= horz_hold;
      resp_reg  <= resp_reg;
    end
  end

  // Tour command valid: raised on load, dropped on acceptance or tour end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rdy_reg <= 1'b0;
    end else if (load_vert || load_horz) begin
      cmd_rdy_reg <= 1'b1;
    end else if (drop_rdy || end_tour) begin
      cmd_rdy_reg <= 1'b0;
    end else begin
      cmd_rdy_reg <= cmd_rdy_reg;
    end
  end

  // Output mux: zero-latency UART pass-through unless a tour owns the processor.
  always_comb begin
    proc.cmd         = cmd_UART;
    proc.cmd_rdy     = cmd_rdy_UART;
    proc.resp        = RESP_DONE;
    clr_cmd_rdy_UART = proc.clr_cmd_rdy;
    if (tour_mode) begin
      proc.cmd         = cmd_reg;
      proc.cmd_rdy     = cmd_rdy_reg;
      proc.resp        = resp_reg;
      clr_cmd_rdy_UART = 1'b0;
    end else begin
      proc.cmd         = cmd_UART;
      proc.cmd_rdy     = cmd_rdy_UART;
      proc.resp        = RESP_DONE;
      clr_cmd_rdy_UART = proc.clr_cmd_rdy;
    end
  end

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Self-checking bench for tour_cmd_sched: table-driven pass-through vectors,
// a move table driving full tours through a command-processor responder with
// a scoreboard queue, plus early-termination and mid-tour reset sequences.
module tb_tour_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_uart;
  logic        cmd_rdy_uart;
  logic        clr_cmd_rdy_uart;

  tour_cmd_sched_if bus ();

  tour_cmd_sched #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_uart),
    .cmd_rdy_UART     (cmd_rdy_uart),
    .clr_cmd_rdy_UART (clr_cmd_rdy_uart),
    .proc             (bus)
  );

  always #5 clk = ~clk;

  // Solver move memory, read combinationally at mv_indx.
  logic [7:0] mem [0:31];
  always_comb move = mem[mv_indx];

  typedef struct {
    logic [15:0] cu;
    logic        ru;
    logic        clr;
    logic [15:0] ecmd;
    logic        erdy;
    logic        eclr;
  } pt_vec_t;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } mv_vec_t;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  resp;
    logic [4:0]  idx;
  } exp_t;

  exp_t    sb[$];
  pt_vec_t pt[6];
  mv_vec_t mt[12];
  int      n_cmp = 0;
  int      n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Command-processor model for one leg: waits for cmd_rdy, holds off the ack,
  // acks twice, optionally pokes start_tour, then signals completion.
  task automatic respond(input exp_t e, input bit poke_start, input bit stop_after_ack);
    int t;
    t = 0;
    while (bus.cmd_rdy !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (bus.cmd_rdy !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_rdy_timeout: got 0 expected 1 for cmd %h", e.cmd);
      return;
    end
    check("tour_cmd", 32'(bus.cmd), 32'(e.cmd));
    check("mv_indx", 32'(mv_indx), 32'(e.idx));
    repeat (2) @(negedge clk);
    check("rdy_held", 32'(bus.cmd_rdy), 32'd1);
    check("cmd_held", 32'(bus.cmd), 32'(e.cmd));
    bus.clr_cmd_rdy = 1'b1;
    #1;
    check("clr_uart_blocked", 32'(clr_cmd_rdy_uart), 32'd0);
    @(negedge clk);
    check("rdy_dropped", 32'(bus.cmd_rdy), 32'd0);
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("rdy_stays_low", 32'(bus.cmd_rdy), 32'd0);
    if (stop_after_ack) return;
    if (poke_start) begin
      start_tour = 1'b1;
      @(negedge clk);
      start_tour = 1'b0;
    end
    check("cmd_stable", 32'(bus.cmd), 32'(e.cmd));
    bus.send_resp = 1'b1;
    #1;
    check("resp", 32'(bus.resp), 32'(e.resp));
    @(negedge clk);
    bus.send_resp = 1'b0;
  endtask

  // Queue the expected legs of moves 0..n-1 of a tour.
  task automatic push_moves(input int n, input int total);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cmd = mt[i % 12].v; e.resp = 8'hA5; e.idx = 5'(i);
      sb.push_back(e);
      e.cmd = mt[i % 12].h; e.resp = (i == total - 1) ? 8'h5A : 8'hA5; e.idx = 5'(i);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   k;

    pt[0] = '{16'h2000, 1'b1, 1'b0, 16'h2000, 1'b1, 1'b0};
    pt[1] = '{16'h2000, 1'b1, 1'b1, 16'h2000, 1'b1, 1'b1};
    pt[2] = '{16'hABCD, 1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1};
    pt[3] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    pt[4] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    pt[5] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};

    mt[0]  = '{8'h01, 16'h4002, 16'h5BF1};
    mt[1]  = '{8'h10, 16'h47F2, 16'h53F1};
    mt[2]  = '{8'h02, 16'h4002, 16'h53F1};
    mt[3]  = '{8'h04, 16'h4001, 16'h53F2};
    mt[4]  = '{8'h08, 16'h47F1, 16'h53F2};
    mt[5]  = '{8'h20, 16'h47F2, 16'h5BF1};
    mt[6]  = '{8'h40, 16'h47F1, 16'h5BF2};
    mt[7]  = '{8'h80, 16'h4001, 16'h5BF2};
    mt[8]  = '{8'h0C, 16'h4001, 16'h53F2};
    mt[9]  = '{8'hF0, 16'h47F2, 16'h53F1};
    mt[10] = '{8'h81, 16'h4002, 16'h5BF1};
    mt[11] = '{8'hFF, 16'h4002, 16'h5BF1};

    for (int i = 0; i < 32; i++) mem[i] = (i < 24) ? mt[i % 12].mv : 8'h00;

    rst             = 1'b1;
    start_tour      = 1'b0;
    cmd_uart        = 16'h0000;
    cmd_rdy_uart    = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_cmd", 32'(bus.cmd), 32'h0000);
    check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("rst_mv_indx", 32'(mv_indx), 32'd0);
    check("rst_clr_uart", 32'(clr_cmd_rdy_uart), 32'd0);
    check("rst_resp", 32'(bus.resp), 32'h5A);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through vectors, checked in the same cycle they are driven.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_uart        = pt[i].cu;
      cmd_rdy_uart    = pt[i].ru;
      bus.clr_cmd_rdy = pt[i].clr;
      #1;
      check("pt_cmd", 32'(bus.cmd), 32'(pt[i].ecmd));
      check("pt_cmd_rdy", 32'(bus.cmd_rdy), 32'(pt[i].erdy));
      check("pt_clr_uart", 32'(clr_cmd_rdy_uart), 32'(pt[i].eclr));
      check("pt_resp", 32'(bus.resp), 32'h5A);
    end
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;

    // send_resp of a UART command in idle leaves the scheduler alone.
    cmd_uart      = 16'h2000;
    cmd_rdy_uart  = 1'b1;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    @(negedge clk);
    check("idle_resp_cmd", 32'(bus.cmd), 32'h2000);
    check("idle_resp_idx", 32'(mv_indx), 32'd0);

    // Full tour with a pending UART command and a mid-tour start_tour.
    push_moves(24, 24);
    pulse_start();
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      respond(e, k == 7, 1'b0);
      k++;
    end
    check("tour_legs", 32'(k), 32'd48);
    #1;
    check("post_tour_cmd", 32'(bus.cmd), 32'h2000);
    check("post_tour_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("post_tour_idx", 32'(mv_indx), 32'd0);
    check("post_tour_resp", 32'(bus.resp), 32'h5A);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    check("post_tour_clr_uart", 32'(clr_cmd_rdy_uart), 32'd1);
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    cmd_rdy_uart    = 1'b0;

    // Tour ended early by an empty move at index 5.
    mem[5]   = 8'h00;
    cmd_uart = 16'h1111;
    push_moves(5, 24);
    pulse_start();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      respond(e, 1'b0, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("early_end_cmd", 32'(bus.cmd), 32'h1111);
    check("early_end_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("early_end_idx", 32'(mv_indx), 32'd0);
    mem[5] = mt[5].mv;

    // Reset while waiting for the horizontal leg of move 1 to complete.
    cmd_uart = 16'h2222;
    push_moves(2, 24);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      respond(e, 1'b0, i == 3);
    end
    check("pre_rst_idx", 32'(mv_indx), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_idx", 32'(mv_indx), 32'd0);
    check("mid_rst_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("mid_rst_cmd", 32'(bus.cmd), 32'h2222);
    check("mid_rst_resp", 32'(bus.resp), 32'h5A);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("after_rst_cmd", 32'(bus.cmd), 32'h2222);
    check("after_rst_rdy", 32'(bus.cmd_rdy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
